// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Holds the state encoding, branch-condition codes and the PC hold target.
package pc_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BOOT,
      ST_RUN,
      ST_FLUSH,
      ST_HALT
   } state_t;

   typedef enum logic [1:0] {
      COND_ALWAYS = 2'd0,
      COND_ZERO   = 2'd1,
      COND_NZERO  = 2'd2,
      COND_NEG    = 2'd3
   } br_cond_t;

   // A relative jump by zero leaves the PC where it is.
   localparam logic [7:0] HOLD_TARGET = 8'h00;

   function automatic logic cond_true(input logic [1:0] sel,
                                      input logic       zero,
                                      input logic       neg);
      logic w_res;
      w_res = 1'b0;
      case (sel)
         COND_ALWAYS: w_res = 1'b1;
         COND_ZERO:   w_res = zero;
         COND_NZERO:  w_res = ~zero;
         COND_NEG:    w_res = neg;
         default:     w_res = 1'b0;
      endcase
      return w_res;
   endfunction

endpackage

// File: rtl/pc_seq_if.sv
// Bundle of decoder/flag inputs and PC-control/status outputs of pc_sequencer.
// master = surrounding datapath, slave = the sequencer.
interface pc_seq_if #(
   parameter int unsigned D  = 12,
   parameter int unsigned CW = 16
);
   logic          start;
   logic          br_rel;
   logic          br_abs;
   logic [1:0]    br_cond;
   logic [7:0]    br_offset;
   logic          halt_req;
   logic          zero_flag;
   logic          neg_flag;
   logic [D-1:0]  prog_ctr;

   logic          pc_reset;
   logic          reljump_en;
   logic          absjump_en;
   logic [7:0]    target;
   logic          instr_valid;
   logic          done;
   logic          timeout;
   logic          bad_branch;
   logic [D-1:0]  halt_pc;
   logic [CW-1:0] cycle_count;

   modport master (
      output start, br_rel, br_abs, br_cond, br_offset, halt_req,
             zero_flag, neg_flag, prog_ctr,
      input  pc_reset, reljump_en, absjump_en, target, instr_valid,
             done, timeout, bad_branch, halt_pc, cycle_count
   );

   modport slave (
      input  start, br_rel, br_abs, br_cond, br_offset, halt_req,
             zero_flag, neg_flag, prog_ctr,
      output pc_reset, reljump_en, absjump_en, target, instr_valid,
             done, timeout, bad_branch, halt_pc, cycle_count
   );
endinterface

// File: rtl/pc_seq_watchdog.sv
// Saturating executing-cycle counter; at_limit flags the last allowed cycle.
module pc_seq_watchdog #(
   parameter int unsigned   CW         = 16,
   parameter logic [CW-1:0] MAX_CYCLES = 16'hFFFF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_clear,
   input  logic          i_count_en,
   output logic [CW-1:0] o_count,
   output logic          o_at_limit
);
   localparam logic [CW-1:0] LIMIT = MAX_CYCLES - CW'(1);

   logic [CW-1:0] r_count;

   assign o_count    = r_count;
   assign o_at_limit = (r_count == LIMIT);

   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_count <= '0;
      end else if (i_count_en && !o_at_limit) begin
         r_count <= r_count + CW'(1);
      end
   end
endmodule

// File: rtl/pc_sequencer.sv
// Control-flow sequencer driving the PC's reset/jump inputs with a watchdog.
// Jump/hold outputs are Mealy so the PC acts on the edge closing the decode cycle.
module pc_sequencer #(
   parameter int unsigned   D          = 12,
   parameter int unsigned   CW         = 16,
   parameter logic [CW-1:0] MAX_CYCLES = 16'hFFFF
) (
   input logic      clk,
   input logic      reset,
   pc_seq_if.slave  bus
);
   import pc_seq_pkg::*;

   state_t        r_state;
   state_t        w_next_state;
   logic          w_pc_reset;
   logic          w_reljump_en;
   logic          w_absjump_en;
   logic [7:0]    w_target;
   logic          w_instr_valid;
   logic          w_halt;
   logic          w_set_timeout;
   logic          w_set_bad;
   logic          w_start_acc;
   logic          w_count_en;
   logic          w_at_limit;
   logic [CW-1:0] w_cycle_count;
   logic [D-1:0]  r_halt_pc;
   logic          r_timeout;
   logic          r_bad_branch;

   assign w_start_acc = bus.start & ((r_state == ST_IDLE) | (r_state == ST_HALT));
   assign w_count_en  = (r_state == ST_RUN) | (r_state == ST_FLUSH);

   pc_seq_watchdog #(
      .CW         (CW),
      .MAX_CYCLES (MAX_CYCLES)
   ) u_watchdog (
      .clk        (clk),
      .reset      (reset),
      .i_clear    (w_start_acc),
      .i_count_en (w_count_en),
      .o_count    (w_cycle_count),
      .o_at_limit (w_at_limit)
   );

   always_comb begin
      w_next_state  = r_state;
      w_pc_reset    = 1'b0;
      w_reljump_en  = 1'b0;
      w_absjump_en  = 1'b0;
      w_target      = HOLD_TARGET;
      w_instr_valid = 1'b0;
      w_halt        = 1'b0;
      w_set_timeout = 1'b0;
      w_set_bad     = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_pc_reset = 1'b1;
            if (bus.start) w_next_state = ST_RUN;
         end
         ST_BOOT: begin
            w_pc_reset   = 1'b1;
            w_next_state = ST_RUN;
         end
         ST_RUN: begin
            w_instr_valid = 1'b1;
            if (w_at_limit) begin
               w_reljump_en  = 1'b1;
               w_halt        = 1'b1;
               w_set_timeout = 1'b1;
               w_next_state  = ST_HALT;
            end else if (bus.halt_req) begin
               w_reljump_en = 1'b1;
               w_halt       = 1'b1;
               w_next_state = ST_HALT;
            end else if ((bus.br_rel || bus.br_abs) &&
                         cond_true(bus.br_cond, bus.zero_flag, bus.neg_flag)) begin
               // Relative wins when both are requested.
               w_reljump_en = bus.br_rel;
               w_absjump_en = ~bus.br_rel;
               w_target     = bus.br_offset;
               w_set_bad    = bus.br_rel & bus.br_abs;
               w_next_state = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (w_at_limit) begin
               w_reljump_en  = 1'b1;
               w_halt        = 1'b1;
               w_set_timeout = 1'b1;
               w_next_state  = ST_HALT;
            end else begin
               w_next_state = ST_RUN;
            end
         end
         ST_HALT: begin
            w_reljump_en = 1'b1;
            if (bus.start) w_next_state = ST_BOOT;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   always_ff @(posedge clk) begin
      if (reset || w_start_acc) begin
         r_halt_pc    <= '0;
         r_timeout    <= 1'b0;
         r_bad_branch <= 1'b0;
      end else begin
         if (w_halt)        r_halt_pc    <= bus.prog_ctr;
         if (w_set_timeout) r_timeout    <= 1'b1;
         if (w_set_bad)     r_bad_branch <= 1'b1;
      end
   end

   assign bus.pc_reset    = w_pc_reset;
   assign bus.reljump_en  = w_reljump_en;
   assign bus.absjump_en  = w_absjump_en;
   assign bus.target      = w_target;
   assign bus.instr_valid = w_instr_valid;
   assign bus.done        = (r_state == ST_HALT);
   assign bus.timeout     = r_timeout;
   assign bus.bad_branch  = r_bad_branch;
   assign bus.halt_pc     = r_halt_pc;
   assign bus.cycle_count = w_cycle_count;
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Control-flow sequencer that drives the program counter's `reset`, `reljump_en`, `absjump_en` and `target` inputs. It evaluates decoded branch requests against ALU flags, starts and halts execution, and inserts one bubble after every taken jump to cover the registered instruction-memory read. A watchdog cycle counter forces a halt on runaway programs. It sits between the instruction decoder/flag register and the program counter.

## Interface
- `D`, 12: program-counter width.
- `CW`, 16: cycle-counter width.
- `MAX_CYCLES`, 16'hFFFF: watchdog limit, counted in executing cycles.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: pulse that begins execution.
- `br_rel`  in  1: decoded relative-jump request.
- `br_abs`  in  1: decoded absolute-jump request.
- `br_cond`  in  2: condition select. 0 = always, 1 = zero, 2 = not zero, 3 = negative.
- `br_offset`  in  8: offset (relative) or address (absolute).
- `halt_req`  in  1: decoded halt instruction.
- `zero_flag`, `neg_flag`  in  1 each: ALU flags.
- `prog_ctr`  in  D: current PC value, fed back.
- `pc_reset`  out  1: drives the PC's `reset`.
- `reljump_en`, `absjump_en`  out  1 each: drive the PC.
- `target`  out  8: drives the PC's `target`.
- `instr_valid`  out  1: current instruction may execute.
- `done`  out  1: high in HALT.
- `timeout`  out  1: sticky; the halt was caused by the watchdog.
- `bad_branch`  out  1: sticky; `br_rel` and `br_abs` were asserted together.
- `halt_pc`  out  D: PC captured at halt.
- `cycle_count`  out  CW: number of executing cycles since the last start.

## Operation
- States:
  - IDLE: `pc_reset`=1.
  - BOOT: `pc_reset`=1, one cycle only.
  - RUN
  - FLUSH: one bubble.
  - HALT
- Transitions:
  - IDLE goes to RUN on `start`.
  - HALT goes to BOOT on `start`. BOOT always goes to RUN.
  - `start` is ignored in RUN and FLUSH.
- Hold mechanism: `reljump_en`=1 with `target`=8'h00, so PC minus 0 plus 0 leaves the PC unchanged.
- In RUN, `instr_valid`=1. Actions in priority order:
  1. Watchdog (`cycle_count` == MAX_CYCLES-1): hold, set `timeout`, capture `halt_pc`=`prog_ctr`, go to HALT.
  2. `halt_req`: hold, capture `halt_pc`, go to HALT.
  3. Taken jump (`br_rel`|`br_abs` with the condition true): assert the matching enable with `target`=`br_offset`, then go to FLUSH. If both requests are set, relative wins and `bad_branch` is set.
  4. Otherwise: no enables, `target`=0, and the PC increments.
  - A jump whose condition is false is not taken: no enables, the PC increments, and the state stays RUN.
- In FLUSH: `instr_valid`=0, all decoder inputs are ignored, no enables, and the PC increments. The watchdog still applies. Next state is RUN.
- In HALT: hold is asserted every cycle, `done`=1, `instr_valid`=0.
- `cycle_count` increments in RUN and FLUSH, saturates at MAX_CYCLES-1, and clears on an accepted `start`.
- `timeout`, `bad_branch` and `halt_pc` clear on an accepted `start`.

## Timing
- Registers: state, `cycle_count`, `halt_pc`, `timeout`, `bad_branch`.
- `reljump_en`, `absjump_en`, `target`, `instr_valid` and `pc_reset` are combinational from the state and the current inputs (Mealy). This lets the PC act on the edge that ends the decode cycle.
- Reset values: state IDLE, `pc_reset`=1, all other outputs 0, `halt_pc`=0, `cycle_count`=0.
- `reset` asserted in any state returns to IDLE on the next edge and overrides `start`.
- The first RUN cycle sees `prog_ctr`=0.
- Taken-jump latency: the PC holds the target 1 cycle later. The next valid instruction comes 2 cycles after the jump.
- `done` rises 1 cycle after the `halt_req` cycle.

## Structure
- Package `pc_seq_pkg` holds:
  - the state enum (IDLE, BOOT, RUN, FLUSH, HALT);
  - the `br_cond` encodings;
  - the `HOLD_TARGET`=8'h00 constant.
- Sub-module `pc_seq_watchdog` holds the saturating cycle counter, its clear, and the `at_limit` compare.

## Test plan
- Start, then 5 plain instructions, then `halt_req`. Required: PC steps 0..5, `halt_pc`=5, `done` from the next cycle, and the PC stays at 5 for 10 or more cycles.
- At PC=3, `br_rel`, `br_cond`=0, offset 8'hFE. Required: PC goes to 1, then 2, and `instr_valid` is low in the cycle with PC=1.
- At PC=4, `br_abs`, `br_cond`=1, offset 8'h20:
  - with `zero_flag`=0: PC goes to 5, no FLUSH;
  - with `zero_flag`=1: PC goes to 0x20, then FLUSH.
- With MAX_CYCLES=8 and no halt: after 8 executing cycles, `timeout`=1 and `done`=1, and `cycle_count` stays at 7. A subsequent `start` clears the flags, goes through BOOT, and the PC restarts at 0.
- `br_rel` and `br_abs` together with offset 8'h02 at PC=6. Required: PC goes to 8 and `bad_branch`=1.
- `reset` asserted during FLUSH, and `start` asserted in the same cycle as `reset`. Required: IDLE, `pc_reset`=1, all flags 0, and `start` ignored.
